// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with per-channel level/edge counting, wrap or saturate,
// sticky overflow, atomic snapshot/clear and a 1-cycle registered shadow read port.
module perf_counter_bank #(
  parameter int                NUM_CH    = 4,
  parameter int                CNT_W     = 32,
  parameter logic [NUM_CH-1:0] EDGE_MASK = '0,
  parameter bit                SATURATE  = 1'b0,
  parameter int                AW        = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              snap,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              ovf_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  live_q   [NUM_CH];
  logic [CNT_W-1:0]  live_d   [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] ovf_sh_q, ovf_sh_d;
  logic [NUM_CH-1:0] prev_q, prev_d;
  logic [NUM_CH-1:0] inc;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_any_q, ovf_any_d;

  // Edge channels only count when the previous sample was low.
  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i] = en & event_in[i] & (~EDGE_MASK[i] | ~prev_q[i]);
    end
  end

  always_comb begin
    live_d = live_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clear) begin
        live_d[i] = '0;
        ovf_d[i]  = 1'b0;
      end else if (inc[i]) begin
        if (live_q[i] != CNT_MAX) begin
          live_d[i] = live_q[i] + CNT_W'(1);
        end else begin
          live_d[i] = SATURATE ? CNT_MAX : '0;
          ovf_d[i]  = 1'b1;
        end
      end
    end
  end

  // Snapshot takes pre-update register values, so snap+clear is an atomic read-and-reset.
  always_comb begin
    shadow_d = shadow_q;
    ovf_sh_d = ovf_sh_q;
    prev_d   = event_in;
    if (snap) begin
      shadow_d = live_q;
      ovf_sh_d = ovf_q;
    end
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    ovf_any_d  = |ovf_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_addr == AW'(i)) begin
          rd_data_d = shadow_q[i];
        end
      end
      if (rd_addr == AW'(NUM_CH)) begin
        rd_data_d = CNT_W'(ovf_sh_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q      <= '0;
      ovf_sh_q   <= '0;
      prev_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_any_q  <= 1'b0;
    end else begin
      live_q     <= live_d;
      shadow_q   <= shadow_d;
      ovf_q      <= ovf_d;
      ovf_sh_q   <= ovf_sh_d;
      prev_q     <= prev_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_any_q  <= ovf_any_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ovf_any  = ovf_any_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: one 32-bit bank plus 8-bit wrap and saturate banks on shared stimulus.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n, en, snap, clear, rd_en;
  logic [3:0]  ev;
  logic [2:0]  rd_addr;
  logic [31:0] m_dat;
  logic        m_vld, m_ovf;
  logic [7:0]  w_dat, s_dat;
  logic        w_vld, w_ovf, s_vld, s_ovf;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .EDGE_MASK(4'b0010), .SATURATE(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .en(en), .event_in(ev), .snap(snap), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(m_dat), .rd_valid(m_vld), .ovf_any(m_ovf));

  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .EDGE_MASK(4'b0010), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .event_in(ev), .snap(snap), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(w_dat), .rd_valid(w_vld), .ovf_any(w_ovf));

  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .EDGE_MASK(4'b0010), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .event_in(ev), .snap(snap), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(s_dat), .rd_valid(s_vld), .ovf_any(s_ovf));

  typedef struct {
    logic        en;
    logic [3:0]  ev;
    logic        snap;
    logic        clear;
    logic        rd_en;
    logic [2:0]  addr;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic en_i, input logic [3:0] ev_i, input logic sn, input logic cl,
                     input logic rd, input logic [2:0] a, input logic chk_i,
                     input logic [31:0] exp_i, input string nm);
    vec_t v;
    v.en = en_i; v.ev = ev_i; v.snap = sn; v.clear = cl; v.rd_en = rd;
    v.addr = a; v.chk = chk_i; v.exp = exp_i; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; en = 1'b0; ev = '0; snap = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    step();
    step();
    check("rst_rd_data", 64'(m_dat), 64'd0);
    check("rst_rd_valid", 64'(m_vld), 64'd0);
    check("rst_ovf_any", 64'(m_ovf), 64'd0);
    check("rst_sat_data", 64'(s_dat), 64'd0);
    rst_n = 1'b1;

    // Level count on ch0, then read every address.
    for (int k = 0; k < 10; k++) add(1, 4'b0001, 0, 0, 0, 0, 0, 0, "t1_cnt");
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0,  "t1_snap");
    add(1, 4'b0000, 0, 0, 1, 0, 1, 10, "t1_rd_ch0");
    add(1, 4'b0000, 0, 0, 0, 0, 1, 10, "t1_hold");
    add(1, 4'b0000, 0, 0, 1, 1, 1, 0,  "t1_rd_ch1");
    add(1, 4'b0000, 0, 0, 1, 2, 1, 0,  "t1_rd_ch2");
    add(1, 4'b0000, 0, 0, 1, 3, 1, 0,  "t1_rd_ch3");
    add(1, 4'b0000, 0, 0, 1, 4, 1, 0,  "t1_rd_ovf");

    // Same pattern on a level channel (ch0) and an edge channel (ch1).
    add(1, 4'b0000, 0, 1, 0, 0, 0, 0, "t2_clr");
    pat = 8'b1110_1011;
    for (int k = 7; k >= 0; k--) add(1, {2'b00, pat[k], pat[k]}, 0, 0, 0, 0, 0, 0, "t2_pat");
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0, "t2_snap");
    add(1, 4'b0000, 0, 0, 1, 0, 1, 6, "t2_level");
    add(1, 4'b0000, 0, 0, 1, 1, 1, 3, "t2_edge");

    // Atomic snap+clear with an event present in the same cycle.
    add(1, 4'b0000, 0, 1, 0, 0, 0, 0, "t4_clr");
    for (int k = 0; k < 50; k++) add(1, 4'b0001, 0, 0, 0, 0, 0, 0, "t4_cnt");
    add(1, 4'b0001, 1, 1, 0, 0, 0, 0,  "t4_snapclr");
    add(1, 4'b0001, 0, 0, 1, 0, 1, 50, "t4_rd_first");
    for (int k = 0; k < 4; k++) add(1, 4'b0001, 0, 0, 0, 0, 0, 0, "t4_cnt2");
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0, "t4_snap2");
    add(1, 4'b0000, 0, 0, 1, 0, 1, 5, "t4_rd_second");
    add(1, 4'b0000, 0, 0, 1, 4, 1, 0, "t4_rd_ovf");

    // en gating, snap in the read cycle, and an out-of-range address.
    for (int k = 0; k < 3; k++) add(1, 4'b0001, 0, 0, 0, 0, 0, 0, "t5_cnt");
    for (int k = 0; k < 4; k++) add(0, 4'b1111, 0, 0, 0, 0, 0, 0, "t5_gated");
    add(0, 4'b1111, 1, 0, 1, 0, 1, 5, "t5_rd_old");
    add(0, 4'b1111, 0, 0, 1, 0, 1, 8, "t5_rd_new");
    add(0, 4'b0000, 0, 0, 1, 5, 1, 0, "t5_rd_oob");
    add(0, 4'b0000, 0, 0, 1, 0, 1, 8, "t5_rd_again");
    add(0, 4'b0000, 0, 0, 1, 1, 1, 0, "t5_rd_ch1");

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; ev = vecs[i].ev; snap = vecs[i].snap; clear = vecs[i].clear;
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].addr;
      step();
      check({vecs[i].name, "_vld"}, 64'(m_vld), 64'(vecs[i].rd_en));
      if (vecs[i].chk) check({vecs[i].name, "_dat"}, 64'(m_dat), 64'(vecs[i].exp));
    end
    snap = 1'b0; clear = 1'b0;

    // Reset while counting and with a read in flight.
    en = 1'b1; ev = 4'b0011; rd_en = 1'b1; rd_addr = 3'd0;
    step();
    check("mid_pre_vld", 64'(m_vld), 64'd1);
    check("mid_pre_dat", 64'(m_dat), 64'd8);
    rst_n = 1'b0;
    step();
    check("mid_rst_vld", 64'(m_vld), 64'd0);
    check("mid_rst_dat", 64'(m_dat), 64'd0);
    check("mid_rst_ovf", 64'(m_ovf), 64'd0);
    rst_n = 1'b1; rd_en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    ev = 4'b0000; snap = 1'b1;
    step();
    snap = 1'b0; rd_en = 1'b1; rd_addr = 3'd0;
    step();
    check("mid_after_ch0", 64'(m_dat), 64'd3);
    rd_addr = 3'd1;
    step();
    check("mid_after_edge_ch1", 64'(m_dat), 64'd1);
    rd_en = 1'b0;

    // 8-bit wrap vs saturate boundary.
    clear = 1'b1;
    step();
    clear = 1'b0; ev = 4'b0001;
    for (int k = 0; k < 256; k++) step();
    check("wrap_ovf_any_lag", 64'(w_ovf), 64'd0);
    step();
    check("wrap_ovf_any", 64'(w_ovf), 64'd1);
    check("sat_ovf_any", 64'(s_ovf), 64'd1);
    check("main_ovf_any", 64'(m_ovf), 64'd0);
    ev = 4'b0000; snap = 1'b1;
    step();
    snap = 1'b0; rd_en = 1'b1; rd_addr = 3'd0;
    step();
    check("wrap_cnt", 64'(w_dat), 64'd1);
    check("sat_cnt", 64'(s_dat), 64'd255);
    check("main_cnt257", 64'(m_dat), 64'd257);
    rd_addr = 3'd4;
    step();
    check("wrap_ovf_word", 64'(w_dat), 64'd1);
    check("sat_ovf_word", 64'(s_dat), 64'd1);
    check("main_ovf_word", 64'(m_dat), 64'd0);
    rd_en = 1'b0; clear = 1'b1;
    step();
    check("clr_ovf_any_lag", 64'(w_ovf), 64'd1);
    clear = 1'b0;
    step();
    check("clr_ovf_any", 64'(w_ovf), 64'd0);
    check("clr_sat_ovf_any", 64'(s_ovf), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
